// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR, steps the datapath through
// fetch / decode / execute / memory / write-back, and stretches each RAM
// access by MEM_WAIT extra cycles. All control outputs are registered.
module instr_sequencer #(
    parameter int          MEM_WAIT = 0,
    parameter logic [7:0]  PC_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] mem_data,
    input  logic        n,
    input  logic        z,
    input  logic        c,
    input  logic        v,
    output logic [7:0]  pc,
    output logic [31:0] ir,
    output logic [1:0]  rw,
    output logic        seladdbus,
    output logic        selldr,
    output logic        reg_we,
    output logic [3:0]  flags,
    output logic [2:0]  state,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LDR, C_STR, C_B, C_BZ, C_HALT
    } class_t;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t      state_reg;
    class_t      iclass_reg;
    class_t      iclass_next;
    logic [3:0]  wait_reg;
    logic [7:0]  pc_reg;
    logic [31:0] ir_reg;
    logic [1:0]  rw_reg;
    logic        seladdbus_reg;
    logic        selldr_reg;
    logic        reg_we_reg;
    logic [3:0]  flags_reg;
    logic        halted_reg;
    logic        access_last;

    assign access_last = (wait_reg == WAIT_LAST);

    // Map the opcode field to an instruction class, registered in DECODE.
    always_comb begin
        iclass_next = C_ALU;
        case (ir_reg[27:24])
            4'b1001: iclass_next = C_LDR;
            4'b1010: iclass_next = C_STR;
            4'b1011: iclass_next = C_B;
            4'b1100: iclass_next = C_BZ;
            4'b1111: iclass_next = C_HALT;
            default: iclass_next = C_ALU;
        endcase
    end

    // Sequencer FSM; strobes are set on the edge that enters their state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            iclass_reg    <= C_ALU;
            wait_reg      <= 4'd0;
            pc_reg        <= PC_RESET;
            ir_reg        <= 32'd0;
            rw_reg        <= RW_NONE;
            seladdbus_reg <= 1'b0;
            selldr_reg    <= 1'b0;
            reg_we_reg    <= 1'b0;
            flags_reg     <= 4'd0;
            halted_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (enable) begin
                        state_reg <= S_FETCH;
                        rw_reg    <= RW_READ;
                        wait_reg  <= 4'd0;
                    end
                end
                S_FETCH: begin
                    if (access_last) begin
                        ir_reg    <= mem_data;
                        pc_reg    <= pc_reg + 8'd1;
                        rw_reg    <= RW_NONE;
                        state_reg <= S_DECODE;
                    end else begin
                        wait_reg <= wait_reg + 4'd1;
                    end
                end
                S_DECODE: begin
                    iclass_reg <= iclass_next;
                    state_reg  <= S_EXEC;
                end
                S_EXEC: begin
                    case (iclass_reg)
                        C_ALU: begin
                            flags_reg  <= {n, z, c, v};
                            reg_we_reg <= 1'b1;
                            selldr_reg <= 1'b0;
                            state_reg  <= S_WB;
                        end
                        C_LDR, C_STR: begin
                            seladdbus_reg <= 1'b1;
                            rw_reg        <= (iclass_reg == C_LDR) ? RW_READ : RW_WRITE;
                            wait_reg      <= 4'd0;
                            state_reg     <= S_MEM;
                        end
                        C_B, C_BZ: begin
                            // BZ tests the Z flag latched by an earlier ALU op.
                            if (iclass_reg == C_B || flags_reg[2]) begin
                                pc_reg <= ir_reg[7:0];
                            end
                            if (enable) begin
                                state_reg <= S_FETCH;
                                rw_reg    <= RW_READ;
                                wait_reg  <= 4'd0;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end
                        C_HALT: begin
                            halted_reg <= 1'b1;
                            state_reg  <= S_HALTED;
                        end
                        default: state_reg <= S_IDLE;
                    endcase
                end
                S_MEM: begin
                    if (access_last) begin
                        rw_reg        <= RW_NONE;
                        seladdbus_reg <= 1'b0;
                        if (iclass_reg == C_LDR) begin
                            reg_we_reg <= 1'b1;
                            selldr_reg <= 1'b1;
                            state_reg  <= S_WB;
                        end else if (enable) begin
                            state_reg <= S_FETCH;
                            rw_reg    <= RW_READ;
                            wait_reg  <= 4'd0;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        wait_reg <= wait_reg + 4'd1;
                    end
                end
                S_WB: begin
                    reg_we_reg <= 1'b0;
                    selldr_reg <= 1'b0;
                    if (enable) begin
                        state_reg <= S_FETCH;
                        rw_reg    <= RW_READ;
                        wait_reg  <= 4'd0;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_HALTED: begin
                    // Only reset leaves this state.
                    state_reg <= S_HALTED;
                end
                default: begin
                    state_reg     <= S_IDLE;
                    rw_reg        <= RW_NONE;
                    seladdbus_reg <= 1'b0;
                    selldr_reg    <= 1'b0;
                    reg_we_reg    <= 1'b0;
                    halted_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = pc_reg;
    assign ir        = ir_reg;
    assign rw        = rw_reg;
    assign seladdbus = seladdbus_reg;
    assign selldr    = selldr_reg;
    assign reg_we    = reg_we_reg;
    assign flags     = flags_reg;
    assign state     = state_reg;
    assign halted    = halted_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Cycle-accurate scoreboard bench: expected per-cycle output records are
// queued up front, a negedge monitor pops and compares one per cycle.
module tb_instr_sequencer;

    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  pc;
        logic [1:0]  rw;
        logic        sa;
        logic        sl;
        logic        we;
        logic        h;
        logic [3:0]  fl;
        logic [31:0] ir;
    } rec_t;

    localparam logic [2:0] ID = 3'd0, FE = 3'd1, DE = 3'd2, EX = 3'd3,
                           ME = 3'd4, WB = 3'd5, HA = 3'd6;

    logic clk = 1'b0;
    logic reset, en0, en2, mon_en;
    always #5 clk = ~clk;

    logic [31:0] ram0 [256];
    logic [31:0] ram2 [256];

    logic [7:0]  pc0, pc2;
    logic [31:0] ir0, ir2, md0, md2;
    logic [1:0]  rw0, rw2;
    logic        sa0, sa2, sl0, sl2, we0, we2, h0, h2;
    logic [3:0]  fl0, fl2, nzcv0, nzcv2;
    logic [2:0]  st0, st2;

    // Small ALU flag model keyed on the latched opcode.
    function automatic logic [3:0] alu_model(input logic [3:0] op);
        case (op)
            4'h1:    return 4'b0100;
            4'h2:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    assign md0   = sa0 ? 32'hDEADBEEF : ram0[pc0];
    assign md2   = sa2 ? 32'hDEADBEEF : ram2[pc2];
    assign nzcv0 = alu_model(ir0[27:24]);
    assign nzcv2 = alu_model(ir2[27:24]);

    instr_sequencer #(.MEM_WAIT(0), .PC_RESET(8'h00)) u0 (
        .clk(clk), .reset(reset), .enable(en0), .mem_data(md0),
        .n(nzcv0[3]), .z(nzcv0[2]), .c(nzcv0[1]), .v(nzcv0[0]),
        .pc(pc0), .ir(ir0), .rw(rw0), .seladdbus(sa0), .selldr(sl0),
        .reg_we(we0), .flags(fl0), .state(st0), .halted(h0)
    );

    instr_sequencer #(.MEM_WAIT(2), .PC_RESET(8'h01)) u2 (
        .clk(clk), .reset(reset), .enable(en2), .mem_data(md2),
        .n(nzcv2[3]), .z(nzcv2[2]), .c(nzcv2[1]), .v(nzcv2[0]),
        .pc(pc2), .ir(ir2), .rw(rw2), .seladdbus(sa2), .selldr(sl2),
        .reg_we(we2), .flags(fl2), .state(st2), .halted(h2)
    );

    rec_t q0[$];
    rec_t q2[$];
    rec_t e0, e2;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   idx0 = 0;
    int   idx2 = 0;

    function automatic rec_t mk(input logic [2:0] st, input logic [7:0] pc,
                                input logic [1:0] rw, input logic sa, input logic sl,
                                input logic we, input logic h, input logic [3:0] fl,
                                input logic [31:0] ir);
        rec_t r;
        r.st = st; r.pc = pc; r.rw = rw; r.sa = sa; r.sl = sl;
        r.we = we; r.h = h; r.fl = fl; r.ir = ir;
        return r;
    endfunction

    task automatic p0(input logic [2:0] st, input logic [7:0] pc, input logic [1:0] rw,
                      input logic sa, input logic sl, input logic we, input logic h,
                      input logic [3:0] fl, input logic [31:0] ir);
        q0.push_back(mk(st, pc, rw, sa, sl, we, h, fl, ir));
    endtask

    task automatic p2(input logic [2:0] st, input logic [7:0] pc, input logic [1:0] rw,
                      input logic sa, input logic sl, input logic we, input logic h,
                      input logic [3:0] fl, input logic [31:0] ir);
        q2.push_back(mk(st, pc, rw, sa, sl, we, h, fl, ir));
    endtask

    task automatic cmp(input string name, input int idx, input rec_t act, input rec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got st=%0d pc=%h rw=%b sa=%b sl=%b we=%b h=%b fl=%b ir=%h; want st=%0d pc=%h rw=%b sa=%b sl=%b we=%b h=%b fl=%b ir=%h",
                     name, idx, act.st, act.pc, act.rw, act.sa, act.sl, act.we, act.h, act.fl, act.ir,
                     exp.st, exp.pc, exp.rw, exp.sa, exp.sl, exp.we, exp.h, exp.fl, exp.ir);
        end else begin
            $display("ok   %s cycle %0d: st=%0d pc=%h rw=%b sa=%b sl=%b we=%b h=%b fl=%b ir=%h",
                     name, idx, act.st, act.pc, act.rw, act.sa, act.sl, act.we, act.h, act.fl, act.ir);
        end
    endtask

    // Monitor: one comparison per DUT per cycle while expectations remain.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                cmp("u0", idx0, mk(st0, pc0, rw0, sa0, sl0, we0, h0, fl0, ir0), e0);
                idx0++;
            end
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                cmp("u2", idx2, mk(st2, pc2, rw2, sa2, sl2, we2, h2, fl2, ir2), e2);
                idx2++;
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; en0 = 1'b0; en2 = 1'b0; mon_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram0[i] = 32'd0;
            ram2[i] = 32'd0;
        end
        ram0[8'h00] = 32'h01180000;   // ALU op1 rd=3 -> flags 0100
        ram0[8'h01] = 32'h0A000000;   // STR
        ram0[8'h02] = 32'h0C000040;   // BZ 40 (taken)
        ram0[8'h40] = 32'h02000000;   // ALU op2 -> flags 1001
        ram0[8'h41] = 32'h0C000040;   // BZ 40 (not taken)
        ram0[8'h42] = 32'h0F000000;   // HALT
        ram2[8'h01] = 32'h09000000;   // LDR
        ram2[8'h02] = 32'h0F000000;   // HALT

        // u0, MEM_WAIT=0: ALU, STR, BZ taken, ALU, BZ not taken, HALT.
        p0(ID, 8'h00, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0);
        p0(FE, 8'h00, 2'b01, 0, 0, 0, 0, 4'h0, 32'h0);
        p0(DE, 8'h01, 2'b00, 0, 0, 0, 0, 4'h0, 32'h01180000);
        p0(EX, 8'h01, 2'b00, 0, 0, 0, 0, 4'h0, 32'h01180000);
        p0(WB, 8'h01, 2'b00, 0, 0, 1, 0, 4'h4, 32'h01180000);
        p0(FE, 8'h01, 2'b01, 0, 0, 0, 0, 4'h4, 32'h01180000);
        p0(DE, 8'h02, 2'b00, 0, 0, 0, 0, 4'h4, 32'h0A000000);
        p0(EX, 8'h02, 2'b00, 0, 0, 0, 0, 4'h4, 32'h0A000000);
        p0(ME, 8'h02, 2'b10, 1, 0, 0, 0, 4'h4, 32'h0A000000);
        p0(FE, 8'h02, 2'b01, 0, 0, 0, 0, 4'h4, 32'h0A000000);
        p0(DE, 8'h03, 2'b00, 0, 0, 0, 0, 4'h4, 32'h0C000040);
        p0(EX, 8'h03, 2'b00, 0, 0, 0, 0, 4'h4, 32'h0C000040);
        p0(FE, 8'h40, 2'b01, 0, 0, 0, 0, 4'h4, 32'h0C000040);
        p0(DE, 8'h41, 2'b00, 0, 0, 0, 0, 4'h4, 32'h02000000);
        p0(EX, 8'h41, 2'b00, 0, 0, 0, 0, 4'h4, 32'h02000000);
        p0(WB, 8'h41, 2'b00, 0, 0, 1, 0, 4'h9, 32'h02000000);
        p0(FE, 8'h41, 2'b01, 0, 0, 0, 0, 4'h9, 32'h02000000);
        p0(DE, 8'h42, 2'b00, 0, 0, 0, 0, 4'h9, 32'h0C000040);
        p0(EX, 8'h42, 2'b00, 0, 0, 0, 0, 4'h9, 32'h0C000040);
        p0(FE, 8'h42, 2'b01, 0, 0, 0, 0, 4'h9, 32'h0C000040);
        p0(DE, 8'h43, 2'b00, 0, 0, 0, 0, 4'h9, 32'h0F000000);
        p0(EX, 8'h43, 2'b00, 0, 0, 0, 0, 4'h9, 32'h0F000000);
        for (int i = 0; i < 5; i++) p0(HA, 8'h43, 2'b00, 0, 0, 0, 1, 4'h9, 32'h0F000000);
        // Reset from HALTED, then B to FF, B (wrap) to 10, LDR with enable dropped.
        p0(ID, 8'h00, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0);
        p0(ID, 8'h00, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0);
        p0(FE, 8'h00, 2'b01, 0, 0, 0, 0, 4'h0, 32'h0);
        p0(DE, 8'h01, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0B0000FF);
        p0(EX, 8'h01, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0B0000FF);
        p0(FE, 8'hFF, 2'b01, 0, 0, 0, 0, 4'h0, 32'h0B0000FF);
        p0(DE, 8'h00, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0B000010);
        p0(EX, 8'h00, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0B000010);
        p0(FE, 8'h10, 2'b01, 0, 0, 0, 0, 4'h0, 32'h0B000010);
        p0(DE, 8'h11, 2'b00, 0, 0, 0, 0, 4'h0, 32'h09000000);
        p0(EX, 8'h11, 2'b00, 0, 0, 0, 0, 4'h0, 32'h09000000);
        p0(ME, 8'h11, 2'b01, 1, 0, 0, 0, 4'h0, 32'h09000000);
        p0(WB, 8'h11, 2'b00, 0, 1, 1, 0, 4'h0, 32'h09000000);
        p0(ID, 8'h11, 2'b00, 0, 0, 0, 0, 4'h0, 32'h09000000);
        p0(ID, 8'h11, 2'b00, 0, 0, 0, 0, 4'h0, 32'h09000000);
        // Async reset in the middle of a FETCH: no IR load.
        for (int i = 0; i < 3; i++) p0(ID, 8'h00, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0);

        // u2, MEM_WAIT=2, PC_RESET=01: LDR then HALT.
        p2(ID, 8'h01, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) p2(FE, 8'h01, 2'b01, 0, 0, 0, 0, 4'h0, 32'h0);
        p2(DE, 8'h02, 2'b00, 0, 0, 0, 0, 4'h0, 32'h09000000);
        p2(EX, 8'h02, 2'b00, 0, 0, 0, 0, 4'h0, 32'h09000000);
        for (int i = 0; i < 3; i++) p2(ME, 8'h02, 2'b01, 1, 0, 0, 0, 4'h0, 32'h09000000);
        p2(WB, 8'h02, 2'b00, 0, 1, 1, 0, 4'h0, 32'h09000000);
        for (int i = 0; i < 3; i++) p2(FE, 8'h02, 2'b01, 0, 0, 0, 0, 4'h0, 32'h09000000);
        p2(DE, 8'h03, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0F000000);
        p2(EX, 8'h03, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0F000000);
        p2(HA, 8'h03, 2'b00, 0, 0, 0, 1, 4'h0, 32'h0F000000);

        step(2);
        reset = 1'b1;
        step(1);                      // cycle 0
        en0 = 1'b1; en2 = 1'b1; mon_en = 1'b1;
        step(23); en0 = 1'b0;         // toggle enable while halted
        step(1);  en0 = 1'b1;
        step(1);  en0 = 1'b0;
        step(1);  en0 = 1'b1;
        step(1);                      // cycle 27: reset out of HALTED
        reset = 1'b0;
        ram0[8'h00] = 32'h0B0000FF;   // B FF
        ram0[8'hFF] = 32'h0B000010;   // B 10
        ram0[8'h10] = 32'h09000000;   // LDR
        ram0[8'h11] = 32'h0F000000;   // would be fetched if reset were ignored
        step(1);  reset = 1'b1;
        step(10); en0 = 1'b0;         // cycle 38: in MEM of the LDR
        step(3);  en0 = 1'b1;         // cycle 41
        step(1);                      // cycle 42: now in FETCH
        reset = 1'b0; en0 = 1'b0;
        step(1);  reset = 1'b1;
        step(2);

        n_cmp++;
        if (q0.size() != 0) begin
            n_bad++;
            $display("FAIL u0 drain: %0d records left, want 0", q0.size());
        end
        n_cmp++;
        if (q2.size() != 0) begin
            n_bad++;
            $display("FAIL u2 drain: %0d records left, want 0", q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
